i2c_phase_gen: RTL
==================

I2C_PHASE_GEN -- requirements
Module: i2c_phase_gen

Interface
- REQ-001 SHALL have parameter CNT_W, default 10, width of the phase counter and of the config inputs.
- REQ-002 SHALL have parameter HALF_RST, default 350, half-period in clk cycles after reset.
- REQ-003 SHALL have parameter OFF_RST, default 174, split offset after reset.
- REQ-004 SHALL have parameter BITS, default 9, bit slots per frame (8 data + ack); legal 1..15.
- REQ-005 clk  in  1  sole clock; all logic on its rising edge.
- REQ-006 rst_n  in  1  synchronous, active-low reset.
- REQ-007 en  in  1  run enable; 0 idles the generator.
- REQ-008 half_period  in  CNT_W  requested half-period H, in clk cycles.
- REQ-009 split_offset  in  CNT_W  requested split offset O.
- REQ-010 cfg_load  in  1  one-cycle request to capture half_period and split_offset.
- REQ-011 cfg_ack  out  1  one-cycle pulse when captured config becomes active.
- REQ-012 stretch_en  in  1  enables target clock stretching.
- REQ-013 scl_in  in  1  SCL line readback, already synchronised.
- REQ-014 scl  out  1  bit clock.
- REQ-015 scl_split  out  1  window centred on the scl falling edge.
- REQ-016 sample_stb, sda_stb, bit_stb, frame_stb  out  1 each  one-cycle strobes.
- REQ-017 bit_idx  out  4  current bit slot, 0..BITS-1.

Function
- REQ-018 Phase counter cnt SHALL run 0..2H-1 and wrap to 0; it advances one per clk while en=1 and not stretched.
- REQ-019 Active H SHALL be max(requested H, 2); active O SHALL be min(requested O, H).
- REQ-020 For counter value k: scl=1 iff k<H; scl_split=1 iff H-O <= k <= H+O-1; with O=0, scl_split SHALL stay 0.
- REQ-021 sample_stb=1 iff k==H>>1; sda_stb=1 iff k==2H-2; bit_stb=1 iff k==2H-1.
- REQ-022 All outputs SHALL be registered and reflect the current k; no combinational path from any input to any output.
- REQ-023 bit_idx SHALL increment on each wrap and roll from BITS-1 to 0; frame_stb SHALL equal bit_stb AND bit_idx==BITS-1.
- REQ-024 Stretch: when stretch_en=1, 2<=k<=H-1 and scl_in=0, cnt SHALL hold; scl stays 1; a strobe SHALL fire only on the first cycle of a held k, never repeat while held.
- REQ-025 cfg_load SHALL copy both config inputs into a shadow and set pending; a later cfg_load before application SHALL overwrite the shadow.
- REQ-026 The pending shadow SHALL become active on the cycle cnt wraps from 2H-1 to 0, or on the next cycle if en=0; cfg_ack SHALL pulse in that cycle and pending SHALL clear.
- REQ-027 cfg_load in the same cycle as a wrap SHALL be applied at the following wrap, not the current one.
- REQ-028 en=0 SHALL force cnt=0, bit_idx=0, scl=1, scl_split=0 and all strobes 0 from the next cycle; en rising SHALL start at k=0 with no skipped strobes.

Reset
- REQ-029 rst_n=0 SHALL force cnt=0, bit_idx=0, active H=HALF_RST, active O=OFF_RST, pending=0.
- REQ-030 During and after reset: scl=1, scl_split=0, cfg_ack=0, all strobes 0.
- REQ-031 Reset asserted mid-cycle or mid-stretch SHALL abandon the bit and discard any pending config.

Verification
- REQ-032 Load H=4, O=2 with en=0, then en=1 -> cfg_ack one pulse; per 8-clk bit scl=1,1,1,1,0,0,0,0; scl_split high at k=2..5; sample_stb k=2, sda_stb k=6, bit_stb k=7.
- REQ-033 H=4, BITS=9, run 72 clks -> bit_idx 0..8 once; one frame_stb coincident with the 9th bit_stb; bit_idx back to 0.
- REQ-034 H=4, stretch_en=1, scl_in=0 for 5 clks from k=2 -> scl high 9 clks; one sample_stb; bit length 13 clks.
- REQ-035 Running H=4, pulse cfg_load H=6, O=0 at k=3 -> H=4 bit completes; cfg_ack at wrap; next bit 12 clks, scl_split stays 0.
- REQ-036 Request H=1, O=5 -> active H=2, O=2; 4-clk bit, scl_split high all 4 clks.
- REQ-037 rst_n low 1 clk at k=5 with a config pending -> next cycle scl=1, k=0, active H=350, no cfg_ack afterwards.

Source files
------------

// File: rtl/i2c_phase_gen.sv
// I2C bit-phase generator: a phase counter over one SCL period with registered
// SCL, split window and per-phase strobes, clock stretching and glitch-free
// reconfiguration at bit boundaries.
module i2c_phase_gen #(
    parameter int unsigned CNT_W    = 10,
    parameter int unsigned HALF_RST = 350,
    parameter int unsigned OFF_RST  = 174,
    parameter int unsigned BITS     = 9
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_half_period,
    input  logic [CNT_W-1:0] i_split_offset,
    input  logic             i_cfg_load,
    output logic             o_cfg_ack,
    input  logic             i_stretch_en,
    input  logic             i_scl_in,
    output logic             o_scl,
    output logic             o_scl_split,
    output logic             o_sample_stb,
    output logic             o_sda_stb,
    output logic             o_bit_stb,
    output logic             o_frame_stb,
    output logic [3:0]       o_bit_idx
);

    // Counter needs one extra bit to reach 2H-1; window maths needs one more.
    localparam int unsigned KW = CNT_W + 1;
    localparam int unsigned XW = CNT_W + 2;
    localparam logic [3:0] LAST_BIT = 4'(BITS - 1);

    logic [KW-1:0]    r_cnt, w_cnt_d;
    logic [3:0]       r_bit_idx, w_bit_idx_d;
    logic [CNT_W-1:0] r_h, r_o, r_sh_h, r_sh_o;
    logic [CNT_W-1:0] w_h_d, w_o_d, w_req_h, w_req_o;
    logic             r_pend, r_run;
    logic             r_scl, r_split, r_sample, r_sda, r_bit, r_frame, r_ack;
    logic [KW-1:0]    w_last, w_last_d;
    logic [XW-1:0]    w_kx, w_hx, w_ox;
    logic             w_stretch, w_wrap_pt, w_wrap, w_apply, w_ok;
    logic             w_scl_d, w_split_d, w_sample_d, w_sda_d, w_bit_d, w_frame_d;

    // Next-state of counter, bit index and active config.
    always_comb begin
        w_last    = {r_h, 1'b0} - KW'(1);
        w_wrap_pt = (r_cnt == w_last);
        // Hold only inside the SCL-high part after the release settles (k>=2).
        w_stretch = r_run & i_en & i_stretch_en & ~i_scl_in
                  & (r_cnt >= KW'(2)) & (r_cnt < {1'b0, r_h});
        w_wrap    = r_run & i_en & ~w_stretch & w_wrap_pt;
        w_apply   = r_pend & (w_wrap | ~i_en);

        w_req_h = (r_sh_h < CNT_W'(2)) ? CNT_W'(2) : r_sh_h;
        w_req_o = (r_sh_o > w_req_h) ? w_req_h : r_sh_o;
        w_h_d   = w_apply ? w_req_h : r_h;
        w_o_d   = w_apply ? w_req_o : r_o;

        w_cnt_d = r_cnt;
        if (!i_en || !r_run) begin
            w_cnt_d = '0;
        end else if (w_stretch) begin
            w_cnt_d = r_cnt;
        end else if (w_wrap_pt) begin
            w_cnt_d = '0;
        end else begin
            w_cnt_d = r_cnt + KW'(1);
        end

        w_bit_idx_d = r_bit_idx;
        if (!i_en) begin
            w_bit_idx_d = '0;
        end else if (w_wrap) begin
            w_bit_idx_d = (r_bit_idx == LAST_BIT) ? 4'd0 : r_bit_idx + 4'd1;
        end
    end

    // Decode outputs from next-state so the registered outputs match the current k.
    always_comb begin
        w_last_d = {w_h_d, 1'b0} - KW'(1);
        w_kx     = {1'b0, w_cnt_d};
        w_hx     = {2'b00, w_h_d};
        w_ox     = {2'b00, w_o_d};
        // A held count must not re-fire the strobe it fired on entry.
        w_ok     = i_en & ~w_stretch;

        w_scl_d    = ~i_en | (w_cnt_d < {1'b0, w_h_d});
        w_split_d  = i_en & (w_o_d != '0) & ((w_kx + w_ox) >= w_hx)
                   & ((w_kx + XW'(1)) <= (w_hx + w_ox));
        w_sample_d = w_ok & (w_cnt_d == KW'(w_h_d >> 1));
        w_sda_d    = w_ok & (w_cnt_d == (w_last_d - KW'(1)));
        w_bit_d    = w_ok & (w_cnt_d == w_last_d);
        w_frame_d  = w_bit_d & (w_bit_idx_d == LAST_BIT);
    end

    // Counter, bit index, config shadow and active config registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_h       <= CNT_W'(HALF_RST);
            r_o       <= CNT_W'(OFF_RST);
            r_sh_h    <= '0;
            r_sh_o    <= '0;
            r_pend    <= 1'b0;
            r_run     <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_d;
            r_bit_idx <= w_bit_idx_d;
            r_h       <= w_h_d;
            r_o       <= w_o_d;
            r_run     <= i_en;
            if (w_apply) begin
                r_pend <= 1'b0;
            end
            // A load on the applying edge becomes the next pending config.
            if (i_cfg_load) begin
                r_sh_h <= i_half_period;
                r_sh_o <= i_split_offset;
                r_pend <= 1'b1;
            end
        end
    end

    // Output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_scl    <= 1'b1;
            r_split  <= 1'b0;
            r_sample <= 1'b0;
            r_sda    <= 1'b0;
            r_bit    <= 1'b0;
            r_frame  <= 1'b0;
            r_ack    <= 1'b0;
        end else begin
            r_scl    <= w_scl_d;
            r_split  <= w_split_d;
            r_sample <= w_sample_d;
            r_sda    <= w_sda_d;
            r_bit    <= w_bit_d;
            r_frame  <= w_frame_d;
            r_ack    <= w_apply;
        end
    end

    assign o_scl        = r_scl;
    assign o_scl_split  = r_split;
    assign o_sample_stb = r_sample;
    assign o_sda_stb    = r_sda;
    assign o_bit_stb    = r_bit;
    assign o_frame_stb  = r_frame;
    assign o_cfg_ack    = r_ack;
    assign o_bit_idx    = r_bit_idx;

endmodule
